dac_playback_ctrl: RTL and testbench
====================================

DAC_PLAYBACK_CTRL -- requirements
Module: dac_playback_ctrl

Interface
REQ-001 SHALL provide parameter: DATA_W, 16, sample width per channel.
REQ-002 SHALL provide parameter: IDLE_CODE, 16'h8000, output code when not playing (midscale).
REQ-003 SHALL have one clock and a synchronous, active-high reset, named as follows.
REQ-004 SHALL have these ports; the first four are in this order:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle trigger that begins playback.
- stop  in  1  one-cycle trigger that aborts playback.
- rate_div  in  16  sample period select; effective period P = max(rate_div,1)+1 clocks.
- burst_len  in  32  samples to play; 0 = continuous.
- fifo_dout  in  32  FIFO read data; [31:16]=channel 1, [15:0]=channel 2.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read strobe; standard FIFO, data valid the cycle after the strobe.
- dac_data_1  out  DATA_W  channel 1 sample.
- dac_data_2  out  DATA_W  channel 2 sample.
- dac_valid  out  1  one-cycle pulse per emitted sample.
- busy  out  1  high in PRIME or RUN.
- done  out  1  one-cycle pulse when a burst completes.
- underflow  out  1  sticky; set on a missed sample.
- samples_sent  out  32  samples emitted since the last start.

Function
REQ-005 SHALL implement the states IDLE, PRIME and RUN.
REQ-006 IDLE->PRIME on start; burst_len and P are latched at this point; samples_sent and underflow clear.
REQ-007 PRIME->RUN on the cycle the prefetch register becomes valid.
REQ-008 RUN->IDLE when samples_sent reaches the latched nonzero burst_len; done pulses in the same cycle as the last dac_valid.
REQ-009 Any state->IDLE on the cycle after stop; stop wins over simultaneous start.
REQ-010 start while busy SHALL be ignored.
REQ-011 Prefetch: one 32-bit holding register (pend) plus pend_valid.
REQ-012 fifo_rd_en SHALL assert only when not IDLE, !fifo_empty, !pend_valid and no read is outstanding; max one read in flight.
REQ-013 Tick: divider counter loaded to P-1 on RUN entry, so the first sample is emitted in the first RUN cycle; afterwards one tick every P clocks.
REQ-014 On tick with pend_valid: dac_data_1 and dac_data_2 load from pend, dac_valid pulses, samples_sent increments, pend_valid clears.
REQ-015 On tick with no pend_valid but read data landing that cycle: the landing word bypasses directly to the outputs, same as REQ-014.
REQ-016 On tick with no data: underflow sets, dac_data holds its last value, dac_valid stays 0, samples_sent is unchanged and playback continues.
REQ-017 On entry to IDLE: dac_data_1 and dac_data_2 take IDLE_CODE; pend and any in-flight read are discarded; the host resets the FIFO before the next start.
REQ-018 samples_sent SHALL wrap modulo 2^32 in continuous mode.

Reset
REQ-019 On reset: state IDLE; dac_data = IDLE_CODE; all strobes, busy, underflow and samples_sent are 0; pend_valid is 0.
REQ-020 Reset mid-operation SHALL drop any in-flight FIFO word.

Configuration
REQ-021 DAC_PLAYBACK_TEST_PATTERN_EN defined: adds input test_pattern (1 bit, latched at start).
- When the latched value is 1, the FIFO is never read.
- Channel 1 is a ramp starting at 0 and incrementing by 1 per sample, wrapping.
- Channel 2 is ~channel 1.
- underflow never sets.
REQ-022 DAC_PLAYBACK_TEST_PATTERN_EN undefined: the port and the ramp logic are absent.

Structure
REQ-023 Package dac_playback_pkg SHALL hold the state enum, the IDLE_CODE default and the bit-field positions of the channels.
REQ-024 The divider SHALL be sub-module sample_rate_tick (inputs: period and load; output: tick).

Verification
REQ-025 rate_div=3, burst_len=4, FIFO preloaded with 0x00010002..0x00070008.
- Required: 4 dac_valid pulses spaced 4 clocks apart.
- Required: first sample ch1=0x0001, ch2=0x0002.
- Required: done with the last sample, then outputs 0x8000 and samples_sent=4.
REQ-026 rate_div=0, continuous, FIFO kept non-empty: dac_valid every 2nd clock and no underflow.
REQ-027 FIFO runs empty after 2 words with rate_div=1.
- Required: underflow=1 and dac_data holds the 2nd word.
- Required: when words are refilled, playback resumes with no stray dac_valid.
REQ-028 stop asserted in RUN with a read in flight.
- Required: IDLE next cycle and outputs 0x8000.
- Required: the landed word is discarded and samples_sent is frozen.
REQ-029 start and stop in the same cycle from IDLE: busy stays 0. start while RUN: no effect on samples_sent.
REQ-030 With DAC_PLAYBACK_TEST_PATTERN_EN defined and test_pattern=1, burst_len=3, rate_div=1.
- Required: ch1 = 0,1,2 and ch2 = 0xFFFF,0xFFFE,0xFFFD.
- Required: fifo_rd_en never asserts.

Source files
------------

// File: rtl/dac_playback_pkg.sv
// Shared types and constants for the DAC playback controller.
package dac_playback_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [15:0] IDLE_CODE_DEFAULT = 16'h8000;

  localparam int unsigned FIFO_W   = 32;
  localparam int unsigned RATE_W   = 16;
  localparam int unsigned PERIOD_W = 17;
  localparam int unsigned COUNT_W  = 32;

  // Channel fields within a FIFO word
  localparam int unsigned CH1_MSB = 31;
  localparam int unsigned CH1_LSB = 16;
  localparam int unsigned CH2_MSB = 15;
  localparam int unsigned CH2_LSB = 0;

  // Sample period in clocks: max(div,1)+1
  function automatic logic [PERIOD_W-1:0] period_of(input logic [RATE_W-1:0] div);
    return (div == '0) ? PERIOD_W'(2) : PERIOD_W'(div) + PERIOD_W'(1);
  endfunction

endpackage

// File: rtl/sample_rate_tick.sv
// Sample-rate divider: one tick every 'period' clocks; load forces an immediate tick.
module sample_rate_tick
  import dac_playback_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [PERIOD_W-1:0] period,
  input  logic                load,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] last;

  assign last = period - PERIOD_W'(1);
  assign tick = (cnt_q == last);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= last;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/dac_playback_ctrl.sv
// Streams FIFO words to a two-channel DAC at a programmable rate with one-word prefetch.
// Optional DAC_PLAYBACK_TEST_PATTERN_EN adds a ramp generator selected by test_pattern.
module dac_playback_ctrl
  import dac_playback_pkg::*;
#(
  parameter int unsigned       DATA_W    = 16,
  parameter logic [DATA_W-1:0] IDLE_CODE = DATA_W'(IDLE_CODE_DEFAULT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [RATE_W-1:0]   rate_div,
  input  logic [COUNT_W-1:0]  burst_len,
  input  logic [FIFO_W-1:0]   fifo_dout,
  input  logic                fifo_empty,
  output logic                fifo_rd_en,
  output logic [DATA_W-1:0]   dac_data_1,
  output logic [DATA_W-1:0]   dac_data_2,
  output logic                dac_valid,
  output logic                busy,
  output logic                done,
  output logic                underflow,
  output logic [COUNT_W-1:0]  samples_sent
`ifdef DAC_PLAYBACK_TEST_PATTERN_EN
  ,
  input  logic                test_pattern
`endif
);

  state_t              state_q, state_d;
  logic [FIFO_W-1:0]   pend_q;
  logic                pend_valid_q;
  logic                rd_pending_q;
  logic [COUNT_W-1:0]  burst_q;
  logic [PERIOD_W-1:0] period_q;
  logic                tp_q;

  logic                tick;
  logic                load;
  logic                start_go;
  logic                land;
  logic                run_tick;
  logic                emit;
  logic                last_sample;
  logic [FIFO_W-1:0]   word;

  assign start_go    = (state_q == ST_IDLE) && start && !stop;
  assign land        = rd_pending_q;
  assign run_tick    = (state_q == ST_RUN) && (state_d == ST_RUN) && tick;
  assign emit        = run_tick && (tp_q || pend_valid_q || land);
  assign word        = pend_valid_q ? pend_q : fifo_dout;
  assign last_sample = (burst_q != '0) && ((samples_sent + COUNT_W'(1)) == burst_q);
  assign busy        = (state_q != ST_IDLE);

  // Combinational so the strobe follows the live empty flag; one read in flight at most
  assign fifo_rd_en = (state_q != ST_IDLE) && (state_d != ST_IDLE) && !reset && !tp_q &&
                      !fifo_empty && !pend_valid_q && !rd_pending_q;

  sample_rate_tick u_tick (
    .clk    (clk),
    .reset  (reset),
    .period (period_q),
    .load   (load),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_go) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (tp_q || land) begin
          state_d = ST_RUN;
          load    = 1'b1;
        end
      end
      ST_RUN: begin
        // done marks the cycle after the last sample was computed
        if (stop || done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef DAC_PLAYBACK_TEST_PATTERN_EN
  logic [DATA_W-1:0] ramp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tp_q   <= 1'b0;
      ramp_q <= '0;
    end else if (start_go) begin
      tp_q   <= test_pattern;
      ramp_q <= '0;
    end else if (emit && tp_q) begin
      ramp_q <= ramp_q + DATA_W'(1);
    end
  end
`else
  assign tp_q = 1'b0;
`endif

  // Prefetch, output sample registers and status
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      rd_pending_q <= 1'b0;
      burst_q      <= '0;
      period_q     <= PERIOD_W'(2);
      dac_data_1   <= IDLE_CODE;
      dac_data_2   <= IDLE_CODE;
      dac_valid    <= 1'b0;
      done         <= 1'b0;
      underflow    <= 1'b0;
      samples_sent <= '0;
    end else begin
      dac_valid <= 1'b0;
      done      <= 1'b0;
      if (start_go) begin
        burst_q      <= burst_len;
        period_q     <= period_of(rate_div);
        samples_sent <= '0;
        underflow    <= 1'b0;
      end
      if (state_d == ST_IDLE) begin
        dac_data_1   <= IDLE_CODE;
        dac_data_2   <= IDLE_CODE;
        pend_valid_q <= 1'b0;
        rd_pending_q <= 1'b0;
      end else begin
        rd_pending_q <= fifo_rd_en;
        if (emit) begin
          dac_valid    <= 1'b1;
          done         <= last_sample;
          samples_sent <= samples_sent + COUNT_W'(1);
          pend_valid_q <= 1'b0;
`ifdef DAC_PLAYBACK_TEST_PATTERN_EN
          if (tp_q) begin
            dac_data_1 <= ramp_q;
            dac_data_2 <= ~ramp_q;
          end else begin
            dac_data_1 <= DATA_W'(word[CH1_MSB:CH1_LSB]);
            dac_data_2 <= DATA_W'(word[CH2_MSB:CH2_LSB]);
          end
`else
          dac_data_1 <= DATA_W'(word[CH1_MSB:CH1_LSB]);
          dac_data_2 <= DATA_W'(word[CH2_MSB:CH2_LSB]);
`endif
        end else begin
          if (land) begin
            pend_q       <= fifo_dout;
            pend_valid_q <= 1'b1;
          end
          if (run_tick) underflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dac_playback_ctrl.sv
// Directed self-checking bench for dac_playback_ctrl with a behavioural FIFO.
module tb_dac_playback_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, stop;
  logic [15:0] rate_div;
  logic [31:0] burst_len;
  logic [31:0] fifo_dout;
  logic        fifo_empty, fifo_rd_en;
  logic [15:0] dac_data_1, dac_data_2;
  logic        dac_valid, busy, done, underflow;
  logic [31:0] samples_sent;
`ifdef DAC_PLAYBACK_TEST_PATTERN_EN
  logic        test_pattern;
`endif

  always #5 clk = ~clk;

  dac_playback_ctrl #(.DATA_W(16), .IDLE_CODE(16'h8000)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .rate_div     (rate_div),
    .burst_len    (burst_len),
    .fifo_dout    (fifo_dout),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .dac_data_1   (dac_data_1),
    .dac_data_2   (dac_data_2),
    .dac_valid    (dac_valid),
    .busy         (busy),
    .done         (done),
    .underflow    (underflow),
    .samples_sent (samples_sent)
`ifdef DAC_PLAYBACK_TEST_PATTERN_EN
    ,
    .test_pattern (test_pattern)
`endif
  );

  // Standard FIFO: data appears the cycle after the read strobe
  logic [31:0] mem [0:127];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_dout <= mem[rd_ptr % 128];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Output log
  int          cyc = 0, nv = 0, n_done = 0, n_rd = 0;
  logic [15:0] v_d1 [0:255];
  logic [15:0] v_d2 [0:255];
  int          v_cyc [0:255];
  logic        v_done [0:255];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dac_valid) begin
      if (nv < 256) begin
        v_d1[nv]   <= dac_data_1;
        v_d2[nv]   <= dac_data_2;
        v_cyc[nv]  <= cyc;
        v_done[nv] <= done;
      end
      nv <= nv + 1;
    end
    if (done) n_done <= n_done + 1;
    if (fifo_rd_en) n_rd <= n_rd + 1;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr % 128] = w;
    wr_ptr++;
  endtask

  task automatic flush();
    wr_ptr = rd_ptr;
  endtask

  task automatic pulse_start(input logic [15:0] rd, input logic [31:0] bl);
    rate_div  = rd;
    burst_len = bl;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_rd(input int budget, input string tag);
    int k = 0;
    while (fifo_rd_en !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(fifo_rd_en), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, bad, s0, nv0, d0, rd0;
    reset = 1'b1; start = 1'b0; stop = 1'b0; rate_div = '0; burst_len = '0;
`ifdef DAC_PLAYBACK_TEST_PATTERN_EN
    test_pattern = 1'b0;
`endif
    cycles(3);
    check("rst_d1", 32'(dac_data_1), 32'h8000);
    check("rst_d2", 32'(dac_data_2), 32'h8000);
    check("rst_valid", 32'(dac_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_samples", samples_sent, 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    reset = 1'b0;
    cycles(2);

    // Burst of 4 at period 4
    flush();
    push(32'h0001_0002); push(32'h0003_0004); push(32'h0005_0006); push(32'h0007_0008);
    base = nv; d0 = n_done;
    pulse_start(16'd3, 32'd4);
    wait_idle(60, "s1_timeout");
    cycles(2);
    check("s1_count", 32'(nv - base), 32'd4);
    bad = 0;
    for (int i = 1; i < 4; i++) if (v_cyc[base+i] - v_cyc[base+i-1] != 4) bad++;
    check("s1_spacing", 32'(bad), 32'd0);
    check("s1_first_ch1", 32'(v_d1[base]), 32'h0001);
    check("s1_first_ch2", 32'(v_d2[base]), 32'h0002);
    check("s1_last_ch1", 32'(v_d1[base+3]), 32'h0007);
    check("s1_last_ch2", 32'(v_d2[base+3]), 32'h0008);
    check("s1_done_last", 32'(v_done[base+3]), 32'd1);
    check("s1_done_first", 32'(v_done[base]), 32'd0);
    check("s1_done_count", 32'(n_done - d0), 32'd1);
    check("s1_idle_d1", 32'(dac_data_1), 32'h8000);
    check("s1_idle_d2", 32'(dac_data_2), 32'h8000);
    check("s1_samples", samples_sent, 32'd4);

    // Continuous at minimum period
    flush();
    for (int k = 0; k < 30; k++) push({16'hA000 + 16'(k), 16'(k)});
    base = nv;
    pulse_start(16'd0, 32'd0);
    cycles(30);
    check("s2_underflow", 32'(underflow), 32'd0);
    check("s2_busy", 32'(busy), 32'd1);
    check("s2_enough", 32'(nv - base >= 12), 32'd1);
    bad = 0;
    for (int i = 1; i < nv - base; i++) if (v_cyc[base+i] - v_cyc[base+i-1] != 2) bad++;
    check("s2_spacing", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < nv - base; i++) if (v_d2[base+i] != 16'(i)) bad++;
    check("s2_order", 32'(bad), 32'd0);
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    check("s2_stop_busy", 32'(busy), 32'd0);
    check("s2_stop_d1", 32'(dac_data_1), 32'h8000);
    cycles(2);
    check("s2_samples", samples_sent, 32'(nv - base));

    // Underflow after two words, then refill
    flush();
    push(32'h1111_2222); push(32'h3333_4444);
    base = nv;
    pulse_start(16'd1, 32'd0);
    cycles(20);
    check("s3_underflow", 32'(underflow), 32'd1);
    check("s3_hold_d1", 32'(dac_data_1), 32'h3333);
    check("s3_hold_d2", 32'(dac_data_2), 32'h4444);
    check("s3_count", 32'(nv - base), 32'd2);
    check("s3_samples", samples_sent, 32'd2);
    check("s3_busy", 32'(busy), 32'd1);
    push(32'h5555_6666); push(32'h7777_8888); push(32'h9999_AAAA);
    cycles(20);
    check("s3_resume_count", 32'(nv - base), 32'd5);
    check("s3_resume_samples", samples_sent, 32'd5);
    check("s3_w3", {16'(v_d1[base+2]), 16'(v_d2[base+2])}, 32'h5555_6666);
    check("s3_w4", {16'(v_d1[base+3]), 16'(v_d2[base+3])}, 32'h7777_8888);
    check("s3_w5", {16'(v_d1[base+4]), 16'(v_d2[base+4])}, 32'h9999_AAAA);
    check("s3_sticky", 32'(underflow), 32'd1);
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    cycles(2);

    // Stop while a read is in flight
    flush();
    for (int k = 0; k < 20; k++) push({16'hC000 + 16'(k), 16'(k)});
    base = nv;
    pulse_start(16'd3, 32'd0);
    begin
      int k = 0;
      while (nv - base < 2 && k < 40) begin
        @(negedge clk);
        k++;
      end
    end
    wait_rd(10, "s4_rd_seen");
    cycles(1);
    s0 = int'(samples_sent); nv0 = nv;
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    check("s4_busy", 32'(busy), 32'd0);
    check("s4_d1", 32'(dac_data_1), 32'h8000);
    check("s4_d2", 32'(dac_data_2), 32'h8000);
    cycles(4);
    check("s4_frozen", samples_sent, 32'(s0));
    check("s4_no_valid", 32'(nv - nv0), 32'd0);
    flush();
    push(32'hABCD_1234);
    base = nv;
    pulse_start(16'd1, 32'd1);
    wait_idle(30, "s4_restart_timeout");
    cycles(1);
    check("s4_restart_count", 32'(nv - base), 32'd1);
    check("s4_restart_word", {16'(v_d1[base]), 16'(v_d2[base])}, 32'hABCD_1234);

    // Reset while a read is in flight
    flush();
    for (int k = 0; k < 10; k++) push({16'hE000 + 16'(k), 16'(k)});
    pulse_start(16'd1, 32'd0);
    cycles(4);
    wait_rd(10, "s6_rd_seen");
    cycles(1);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    check("s6_busy", 32'(busy), 32'd0);
    check("s6_samples", samples_sent, 32'd0);
    check("s6_d1", 32'(dac_data_1), 32'h8000);
    flush();
    push(32'h1357_2468);
    base = nv;
    pulse_start(16'd1, 32'd1);
    wait_idle(30, "s6_restart_timeout");
    cycles(1);
    check("s6_restart_word", {16'(v_d1[base]), 16'(v_d2[base])}, 32'h1357_2468);

    // start+stop together from IDLE, and start while running
    flush();
    rate_div = 16'd1; burst_len = 32'd0;
    start = 1'b1; stop = 1'b1;
    cycles(1);
    start = 1'b0; stop = 1'b0;
    check("s5_startstop_busy", 32'(busy), 32'd0);
    cycles(3);
    check("s5_startstop_busy2", 32'(busy), 32'd0);
    for (int k = 0; k < 10; k++) push({16'hD000 + 16'(k), 16'(k)});
    base = nv; d0 = n_done;
    pulse_start(16'd1, 32'd6);
    cycles(6);
    check("s5_running", 32'(busy), 32'd1);
    pulse_start(16'd5, 32'd2);
    wait_idle(60, "s5_timeout");
    cycles(1);
    check("s5_count", 32'(nv - base), 32'd6);
    check("s5_samples", samples_sent, 32'd6);
    check("s5_done", 32'(n_done - d0), 32'd1);
    check("s5_rate_kept", 32'(v_cyc[base+5] - v_cyc[base+4]), 32'd2);

`ifdef DAC_PLAYBACK_TEST_PATTERN_EN
    flush();
    test_pattern = 1'b1;
    rd0 = n_rd;
    base = nv;
    pulse_start(16'd1, 32'd3);
    test_pattern = 1'b0;
    wait_idle(40, "tp_timeout");
    cycles(1);
    check("tp_count", 32'(nv - base), 32'd3);
    check("tp_s0", {16'(v_d1[base]),   16'(v_d2[base])},   32'h0000_FFFF);
    check("tp_s1", {16'(v_d1[base+1]), 16'(v_d2[base+1])}, 32'h0001_FFFE);
    check("tp_s2", {16'(v_d1[base+2]), 16'(v_d2[base+2])}, 32'h0002_FFFD);
    check("tp_no_reads", 32'(n_rd - rd0), 32'd0);
    check("tp_underflow", 32'(underflow), 32'd0);
    check("tp_samples", samples_sent, 32'd3);
`else
    rd0 = 0;
    if (rd0 != 0) $display("unreachable");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
